// File: rtl/str_tx.sv
// str_tx: byte-stream string transmitter.
// Buffers up to DEPTH non-null characters. On start it streams them one byte
// per valid/ready handshake, then sends a single 0x00 terminator. The buffer is
// kept after the transfer, so the same string can be sent again.
// Optional feature: define STR_TX_STATS_EN to add the n_cnt port. n_cnt counts
// the 'N'/'n' bytes sent in the current or most recent transfer.
module str_tx #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clear,
  input  logic          start,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          full,
  output logic [AW:0]   len
`ifdef STR_TX_STATS_EN
  ,
  output logic [AW:0]   n_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_TERM = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [7:0]    buf_mem [DEPTH];
  logic [1:0]    state_reg;
  logic [AW:0]   len_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [7:0]    out_data_reg;
  logic          out_valid_reg;
  logic          done_reg;

  logic          in_idle;
  logic          wr_accept;
  logic [AW-1:0] wr_addr;
  logic          start_accept;
  logic          have_chars;
  logic          xfer;
  logic          last_char;
  logic [AW-1:0] next_idx;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_byte;

  assign in_idle = (state_reg == ST_IDLE);

  // A write is taken only in IDLE and only for non-null data. While clear is
  // asserted, the byte lands in slot 0 even if the buffer was full.
  assign wr_accept = in_idle && wr_en && (wr_data != 8'h00) && (clear || !full);
  assign wr_addr   = clear ? '0 : len_reg[AW-1:0];

  // clear takes priority over start.
  assign start_accept = in_idle && start && !clear;

  // A write in the same cycle as start counts toward this transfer.
  assign have_chars = (len_reg != '0) || wr_accept;

  assign xfer      = out_valid_reg && out_ready;
  assign last_char = ((rd_ptr_reg + 1'b1) == len_reg);
  assign next_idx  = rd_ptr_reg[AW-1:0] + 1'b1;

  // One read port. In IDLE it fetches slot 0 for the first byte. In SEND it
  // fetches the byte after the one now being transferred.
  assign rd_addr = in_idle ? '0 : next_idx;

  // An empty buffer cannot supply slot 0 in the start cycle, because the write
  // happening in that cycle is not stored yet. Bypass wr_data in that case.
  assign rd_byte = (in_idle && (len_reg == '0)) ? wr_data : buf_mem[rd_addr];

  assign full      = (len_reg == (AW + 1)'(DEPTH));
  assign len       = len_reg;
  assign busy      = (state_reg == ST_SEND) || (state_reg == ST_TERM);
  assign done      = done_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;

  // Character storage: write port only. The contents are not cleared on reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      buf_mem[wr_addr] <= wr_data;
    end
  end

  // Control FSM with a registered output stage. out_data/out_valid change only
  // on a transfer, so they stay stable under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      rd_ptr_reg    <= '0;
      out_data_reg  <= 8'h00;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (clear) begin
            len_reg <= wr_accept ? (AW + 1)'(1) : '0;
          end else if (wr_accept) begin
            len_reg <= len_reg + 1'b1;
          end
          if (start_accept) begin
            rd_ptr_reg    <= '0;
            out_valid_reg <= 1'b1;
            if (have_chars) begin
              state_reg    <= ST_SEND;
              out_data_reg <= rd_byte;
            end else begin
              state_reg    <= ST_TERM;
              out_data_reg <= 8'h00;
            end
          end
        end
        ST_SEND: begin
          if (xfer) begin
            if (last_char) begin
              state_reg    <= ST_TERM;
              out_data_reg <= 8'h00;
            end else begin
              rd_ptr_reg   <= rd_ptr_reg + 1'b1;
              out_data_reg <= rd_byte;
            end
          end
        end
        ST_TERM: begin
          if (xfer) begin
            state_reg     <= ST_DONE;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b1;
          end
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef STR_TX_STATS_EN
  logic [AW:0] n_cnt_reg;

  // Count the 'N'/'n' bytes in the current transfer. The value holds after
  // DONE until the next start.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_cnt_reg <= '0;
    end else if (start_accept) begin
      n_cnt_reg <= '0;
    end else if ((state_reg == ST_SEND) && xfer &&
                 ((out_data_reg == 8'h4E) || (out_data_reg == 8'h6E))) begin
      n_cnt_reg <= n_cnt_reg + 1'b1;
    end
  end

  assign n_cnt = n_cnt_reg;
`endif

endmodule

// File: tb/tb_str_tx.sv
// Testbench for str_tx. The model holds the buffer as a queue of characters.
// Each transfer is checked against (queue contents + 0x00), with random
// backpressure and ignored control noise applied during the transfer.
module tb_str_tx;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clear;
  logic          start;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          full;
  logic [AW:0]   len;
`ifdef STR_TX_STATS_EN
  logic [AW:0]   n_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] model[$];

  str_tx #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .clear(clear), .start(start), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .full(full), .len(len)
`ifdef STR_TX_STATS_EN
    , .n_cnt(n_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
    if (b != 8'h00 && model.size() < DEPTH) model.push_back(b);
    chk("len_after_write", 32'(len), 32'(model.size()));
    chk("full_flag", 32'(full), 32'(model.size() == DEPTH));
    $display("write %02h -> len=%0d full=%0b", b, len, full);
  endtask

  task automatic do_clear(input bit with_write, input logic [7:0] b);
    clear = 1'b1;
    wr_en = with_write;
    wr_data = b;
    @(negedge clk);
    clear = 1'b0;
    wr_en = 1'b0;
    model.delete();
    if (with_write && b != 8'h00) model.push_back(b);
    chk("len_after_clear", 32'(len), 32'(model.size()));
    $display("clear (write=%0b %02h) -> len=%0d", with_write, b, len);
  endtask

  function automatic int count_n(input logic [7:0] q[$]);
    int n = 0;
    foreach (q[i]) if (q[i] == 8'h4E || q[i] == 8'h6E) n++;
    return n;
  endfunction

  // Start a transfer and follow it through to DONE. extra is written in the
  // start cycle and must show up in the stream.
  task automatic send(input int unsigned stall_pct, input bit noise, input logic [7:0] extra);
    logic [7:0] exp_q[$];
    logic [7:0] held;
    bit stalled;
    int idx;
    int cyc;
    start = 1'b1;
    wr_en = (extra != 8'h00);
    wr_data = extra;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    if (extra != 8'h00 && model.size() < DEPTH) model.push_back(extra);
    exp_q = model;
    exp_q.push_back(8'h00);
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    held = 8'h00;
    while (idx < exp_q.size() && cyc < 400) begin
      if (stalled) chk("held_data", 32'(out_data), 32'(held));
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("busy", 32'(busy), 32'd1);
      chk("out_data", 32'(out_data), 32'(exp_q[idx]));
      out_ready = ($urandom_range(0, 99) >= stall_pct);
      stalled = !out_ready;
      held = out_data;
      if (out_ready) begin
        $display("xfer %0d: data=%02h exp=%02h", idx, out_data, exp_q[idx]);
        idx++;
      end
      if (noise) begin
        wr_en = 1'($urandom_range(0, 1));
        wr_data = 8'($urandom_range(1, 255));
        clear = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    wr_en = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    chk("transfer_count", 32'(idx), 32'(exp_q.size()));
    chk("done_pulse", 32'(done), 32'd1);
    chk("valid_after_term", 32'(out_valid), 32'd0);
    chk("busy_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("len_retained", 32'(len), 32'(model.size()));
`ifdef STR_TX_STATS_EN
    chk("n_cnt", 32'(n_cnt), 32'(count_n(model)));
`endif
    $display("send done: %0d bytes + terminator in %0d cycles", model.size(), cyc);
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    clear = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_len", 32'(len), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // "Ab" with ready held high: exact byte-per-cycle timing.
    do_write(8'h41);
    do_write(8'h62);
    send(0, 1'b0, 8'h00);

    // A null write is dropped. Then send an empty string.
    do_write(8'h00);
    do_clear(1'b0, 8'h00);
    send(0, 1'b0, 8'h00);

    // Full-depth string; the extra write is ignored.
    for (int i = 0; i < DEPTH; i++) do_write(8'($urandom_range(1, 255)));
    chk("full_at_depth", 32'(full), 32'd1);
    do_write(8'h5A);
    send(30, 1'b0, 8'h00);

    // Replay the same buffer under heavy backpressure and control noise.
    send(40, 1'b1, 8'h00);

    // clear+wr_en leaves one char. start+wr_en adds the char to the stream.
    do_clear(1'b1, 8'h55);
    send(0, 1'b0, 8'h66);

    // "abc" with noise during the send.
    do_clear(1'b0, 8'h00);
    do_write(8'h61);
    do_write(8'h62);
    do_write(8'h63);
    send(50, 1'b1, 8'h00);

    // Random strings.
    for (int r = 0; r < 5; r++) begin
      int n;
      do_clear(1'b0, 8'h00);
      n = int'($urandom_range(0, DEPTH + 2));
      for (int i = 0; i < n; i++)
        do_write(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      send($urandom_range(0, 60), 1'b1,
           ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00);
    end

    // "nNx" sent twice.
    do_clear(1'b0, 8'h00);
    do_write(8'h6E);
    do_write(8'h4E);
    do_write(8'h78);
    send(20, 1'b0, 8'h00);
    send(0, 1'b0, 8'h00);

    // Reset in the middle of SEND aborts without a terminator.
    do_clear(1'b0, 8'h00);
    for (int i = 0; i < 6; i++) do_write(8'($urandom_range(1, 255)));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    model.delete();
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_len", 32'(len), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    $display("reset mid-send -> valid=%0b len=%0d busy=%0b", out_valid, len, busy);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_terminator", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
